// File: rtl/mem_port_arbiter_pkg.sv
// tinker_mem_pkg: shared types and constants for the unified memory port
// arbiter and its neighbours in tinker_core.
package tinker_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [63:0] RESET_PC = 64'h2000;
    localparam int unsigned MEM_SIZE = 524288;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_resp_valid;
    logic [31:0]       if_rdata;

    logic              d_valid;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_ready;
    logic              d_resp_valid;
    logic [63:0]       d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport slave (
        input  if_valid, if_addr,
        output if_ready, if_resp_valid, if_rdata,
        input  d_valid, d_we, d_addr, d_wdata,
        output d_ready, d_resp_valid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_valid, if_addr,
        input  if_ready, if_resp_valid, if_rdata,
        output d_valid, d_we, d_addr, d_wdata,
        input  d_ready, d_resp_valid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_perf.sv
// mem_arb_perf: saturating grant and fetch-stall counters for the memory
// port arbiter; only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic        if_hs,
    input  logic        d_hs,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_if_stall
);

    // Count grants and fetch stall cycles, sticking at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_grants <= '0;
            perf_d_grants  <= '0;
            perf_if_stall  <= '0;
        end else begin
            if (if_hs && perf_if_grants != '1)
                perf_if_grants <= perf_if_grants + 32'd1;
            if (d_hs && perf_d_grants != '1)
                perf_d_grants <= perf_d_grants + 32'd1;
            if (if_valid && !if_hs && perf_if_stall != '1)
                perf_if_stall <= perf_if_stall + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: blocking fetch/data arbiter for the unified memory,
// data-first with a fetch starvation guard. Option: MEM_ARB_PERF_EN.
module mem_port_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_if_stall
`endif
);

    localparam logic [3:0] LAT   = 4'(MEM_LAT);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    owner_t            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [3:0]        lat_q;
    logic [7:0]        starve_q;
    logic [31:0]       if_rdata_q;
    logic [63:0]       d_rdata_q;
    logic              arb;
    logic              if_win;
    logic              if_hs;
    logic              d_hs;
    logic              lat_done;

    assign arb      = (state_q == IDLE) || (state_q == RESP);
    assign if_win   = bus.if_valid &&
                      (!bus.d_valid || starve_q >= LIMIT);
    assign if_hs    = arb && if_win;
    assign d_hs     = arb && bus.d_valid && !if_win;
    assign lat_done = (lat_q == 4'd1);

    assign bus.if_ready  = if_hs;
    assign bus.d_ready   = d_hs;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state plus the memory strobe and response pulses.
    always_comb begin
        state_d           = state_q;
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.if_resp_valid = 1'b0;
        bus.d_resp_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_hs || d_hs) state_d = ISSUE;
            end
            ISSUE: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = we_q;
                state_d     = WAIT;
            end
            WAIT: begin
                if (lat_done) state_d = RESP;
            end
            RESP: begin
                bus.if_resp_valid = (owner_q == OWN_IF);
                bus.d_resp_valid  = (owner_q == OWN_D);
                state_d = (if_hs || d_hs) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, latency countdown and response data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_hs || d_hs) begin
                owner_q <= if_hs ? OWN_IF : OWN_D;
                we_q    <= d_hs && bus.d_we;
                addr_q  <= if_hs ? bus.if_addr : bus.d_addr;
                wdata_q <= if_hs ? 64'd0 : bus.d_wdata;
            end
            if (state_q == ISSUE)
                lat_q <= LAT;
            else if (state_q == WAIT)
                lat_q <= lat_q - 4'd1;
            if (state_q == WAIT && lat_done) begin
                if (owner_q == OWN_IF)
                    if_rdata_q <= bus.mem_rdata[31:0];
                else if (!we_q)
                    d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Fetch starvation counter: grows per lost arbitration, clears on
    // a fetch grant or whenever fetch stops asking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_q <= '0;
        else if (!bus.if_valid || if_hs)
            starve_q <= '0;
        else if (arb && starve_q != 8'hFF)
            starve_q <= starve_q + 8'd1;
    end

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (bus.if_valid),
        .if_hs          (if_hs),
        .d_hs           (d_hs),
        .perf_if_grants (perf_if_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_if_stall  (perf_if_stall)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// at MEM_LAT 1 and 3. Define MEM_ARB_PERF_EN to also cover the counters.
module tb_mem_port_arbiter;

    localparam int AW  = 64;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(AW)) b3 ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] p1_ifg, p1_dg, p1_st;
    logic [31:0] p3_ifg, p3_dg, p3_st;
`endif

    mem_port_arbiter #(
        .ADDR_W(AW), .MEM_LAT(1), .STARVE_LIMIT(LIM)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants (p1_ifg),
        .perf_d_grants  (p1_dg),
        .perf_if_stall  (p1_st)
`endif
    );

    mem_port_arbiter #(
        .ADDR_W(AW), .MEM_LAT(3), .STARVE_LIMIT(LIM)
    ) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants (p3_ifg),
        .perf_d_grants  (p3_dg),
        .perf_if_stall  (p3_st)
`endif
    );

    // Memory: 128 words indexed by addr[9:3]; read data is only
    // valid exactly LAT cycles after mem_req, junk otherwise.
    logic [63:0] mem [0:127];
    int          mcyc = 0;
    int          due1 = -1;
    int          due3 = -1;
    logic [63:0] dat1, dat3;

    always @(posedge clk) mcyc <= mcyc + 1;

    always @(negedge clk) begin
        if (b1.mem_req === 1'b1) begin
            due1 = mcyc + 1;
            dat1 = mem[b1.mem_addr[9:3]];
            if (b1.mem_we) mem[b1.mem_addr[9:3]] = b1.mem_wdata;
        end
        b1.mem_rdata = (mcyc == due1) ? dat1 : {$urandom, $urandom};
    end

    always @(negedge clk) begin
        if (b3.mem_req === 1'b1) begin
            due3 = mcyc + 3;
            dat3 = mem[b3.mem_addr[9:3]];
            if (b3.mem_we) mem[b3.mem_addr[9:3]] = b3.mem_wdata;
        end
        b3.mem_rdata = (mcyc == due3) ? dat3 : {$urandom, $urandom};
    end

    function automatic logic [63:0] raddr();
        int r;
        r = $urandom_range(0, 127);
        return 64'(r) << 3;
    endfunction

    task automatic idle_inputs();
        b1.if_valid = 0; b1.if_addr = '0;
        b1.d_valid = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.if_valid = 0; b3.if_addr = '0;
        b3.d_valid = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({b1.if_ready, b1.if_resp_valid, b1.d_ready, b1.d_resp_valid,
             b1.mem_req, b1.mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0",
                     {b1.if_ready, b1.if_resp_valid, b1.d_ready,
                      b1.d_resp_valid, b1.mem_req, b1.mem_we});
        end
        checks++;
        if ({b1.if_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", b1.if_rdata,
                     b1.d_rdata, b1.mem_addr, b1.mem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        logic [63:0] a;
        a = 64'h2000;
        mem[a[9:3]] = {32'h5555AAAA, 32'h1234ABCD};
        @(negedge clk);
        b1.if_valid = 1; b1.if_addr = a;
        #1;
        checks++;
        if (b1.if_ready !== 1'b1) begin
            errors++; $display("FAIL fetch_ready got %b exp 1", b1.if_ready);
        end
        @(negedge clk);
        b1.if_valid = 0;
        #1;
        checks++;
        if ({b1.mem_req, b1.mem_we, b1.mem_addr} !== {2'b10, a}) begin
            errors++;
            $display("FAIL fetch_issue got req=%b we=%b addr=%h exp 1 0 %h",
                     b1.mem_req, b1.mem_we, b1.mem_addr, a);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({b1.mem_req, b1.if_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_wait got req=%b resp=%b exp 0 0",
                     b1.mem_req, b1.if_resp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (b1.if_resp_valid !== 1'b1 || b1.if_rdata !== 32'h1234ABCD) begin
            errors++;
            $display("FAIL fetch_resp got v=%b d=%h exp 1 1234abcd",
                     b1.if_resp_valid, b1.if_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (b1.if_resp_valid !== 1'b0 || b1.if_rdata !== 32'h1234ABCD) begin
            errors++;
            $display("FAIL fetch_hold got v=%b d=%h exp 0 1234abcd",
                     b1.if_resp_valid, b1.if_rdata);
        end
    endtask

    task automatic test_store_load();
        logic [63:0] a, w;
        a = 64'h100;
        w = 64'hDEADBEEF_00000001;
        @(negedge clk);
        b1.d_valid = 1; b1.d_we = 1; b1.d_addr = a; b1.d_wdata = w;
        #1;
        checks++;
        if (b1.d_ready !== 1'b1 || b1.if_ready !== 1'b0) begin
            errors++; $display("FAIL st_ready got %b exp 1", b1.d_ready);
        end
        @(negedge clk);
        b1.d_valid = 0; b1.d_we = 0;
        #1;
        checks++;
        if ({b1.mem_req, b1.mem_we, b1.mem_addr, b1.mem_wdata}
            !== {2'b11, a, w}) begin
            errors++;
            $display("FAIL st_issue got %b %b %h %h exp 1 1 %h %h",
                     b1.mem_req, b1.mem_we, b1.mem_addr, b1.mem_wdata, a, w);
        end
        @(negedge clk);
        @(negedge clk);
        b1.d_valid = 1; b1.d_we = 0; b1.d_addr = a; b1.d_wdata = '0;
        #1;
        checks++;
        if (b1.d_resp_valid !== 1'b1 || b1.d_rdata !== 64'd0) begin
            errors++;
            $display("FAIL st_ack got v=%b d=%h exp 1 0",
                     b1.d_resp_valid, b1.d_rdata);
        end
        checks++;
        if (b1.d_ready !== 1'b1) begin
            errors++; $display("FAIL ld_b2b_ready got %b exp 1", b1.d_ready);
        end
        @(negedge clk);
        b1.d_valid = 0;
        #1;
        checks++;
        if ({b1.mem_req, b1.mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL ld_issue got %b%b exp 10", b1.mem_req, b1.mem_we);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (b1.d_resp_valid !== 1'b1 || b1.d_rdata !== w) begin
            errors++;
            $display("FAIL ld_resp got v=%b d=%h exp 1 %h",
                     b1.d_resp_valid, b1.d_rdata, w);
        end
    endtask

    // Both requesters held high: the arbitration opportunities are every
    // third cycle and the fifth of each group of five goes to fetch.
    task automatic test_starvation();
        bit ea, ei, ed;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            b1.if_valid = 1; b1.if_addr = 64'h2000;
            b1.d_valid = 1; b1.d_we = 0; b1.d_addr = 64'h100;
            #1;
            ea = (c % 3 == 0);
            ei = ea && ((c / 3) % 5 == 4);
            ed = ea && !ei;
            checks++;
            if (b1.if_ready !== ei || b1.d_ready !== ed) begin
                errors++;
                $display("FAIL starve c=%0d got if=%b d=%b exp if=%b d=%b",
                         c, b1.if_ready, b1.d_ready, ei, ed);
            end
            checks++;
            if (b1.if_ready === 1'b1 && b1.d_ready === 1'b1) begin
                errors++;
                $display("FAIL both_ready c=%0d got 11 exp not both", c);
            end
        end
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency3();
        logic [63:0] a;
        a = 64'h2A8;
        mem[a[9:3]] = 64'h0123456789ABCDEF;
        @(negedge clk);
        b3.if_valid = 1; b3.if_addr = a;
        #1;
        checks++;
        if (b3.if_ready !== 1'b1) begin
            errors++; $display("FAIL l3_ready got %b exp 1", b3.if_ready);
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            b3.if_valid = 0;
            b3.d_valid = (c == 5); b3.d_we = 0; b3.d_addr = 64'h100;
            #1;
            checks++;
            if (b3.if_resp_valid !== (c == 5) ||
                b3.d_resp_valid !== (c == 10)) begin
                errors++;
                $display("FAIL l3_resp c=%0d got if=%b d=%b", c,
                         b3.if_resp_valid, b3.d_resp_valid);
            end
            if (c == 1) begin
                checks++;
                if (b3.mem_req !== 1'b1 || b3.mem_addr !== a) begin
                    errors++;
                    $display("FAIL l3_issue got %b %h exp 1 %h",
                             b3.mem_req, b3.mem_addr, a);
                end
            end
            if (c == 5) begin
                checks++;
                if (b3.if_rdata !== 32'h89ABCDEF || b3.d_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL l3_data got %h rdy=%b exp 89abcdef 1",
                             b3.if_rdata, b3.d_ready);
                end
            end
            if (c == 10) begin
                checks++;
                if (b3.d_rdata !== 64'hDEADBEEF_00000001) begin
                    errors++;
                    $display("FAIL l3_ld got %h exp deadbeef00000001",
                             b3.d_rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [63:0] a;
        a = 64'h8;
        mem[a[9:3]] = 64'h0BADF00D_CAFE0123;
        @(negedge clk);
        b1.if_valid = 1; b1.if_addr = 64'h2000;
        @(negedge clk);
        b1.if_valid = 0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({b1.mem_req, b1.if_resp_valid, b1.d_resp_valid,
             b1.if_rdata, b1.d_rdata, b1.mem_addr} !== '0) begin
            errors++;
            $display("FAIL rst_mid got req=%b rv=%b rd=%h %h addr=%h exp 0",
                     b1.mem_req, b1.if_resp_valid, b1.if_rdata,
                     b1.d_rdata, b1.mem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (b1.if_resp_valid !== 1'b0 || b1.d_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_noresp c=%0d got %b %b exp 0 0", c,
                         b1.if_resp_valid, b1.d_resp_valid);
            end
        end
        @(negedge clk);
        b1.if_valid = 1; b1.if_addr = a;
        #1;
        checks++;
        if (b1.if_ready !== 1'b1) begin
            errors++; $display("FAIL rst_fetch_rdy got %b exp 1", b1.if_ready);
        end
        @(negedge clk);
        b1.if_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (b1.if_resp_valid !== 1'b1 || b1.if_rdata !== 32'hCAFE0123) begin
            errors++;
            $display("FAIL rst_fetch got v=%b d=%h exp 1 cafe0123",
                     b1.if_resp_valid, b1.if_rdata);
        end
    endtask

    // Transaction-level reference: each grant books the memory port for
    // MEM_LAT+2 cycles; reads see memory as left by earlier grants.
    task automatic test_random();
        logic [63:0] rmem [0:127];
        bit          iv, dv, dwe, arb, gi, gd, rsp_if, rsp_we, iss_we;
        logic [63:0] ia, da, dwd, iss_addr, iss_wd, rsp_dat, e_drd;
        logic [31:0] e_ird;
        int          nxt, iss_c, rsp_c, starve;
        bit          e_ir, e_dr, e_req;
        pulse_reset();
        for (int i = 0; i < 128; i++) rmem[i] = mem[i];
        iv = 0; dv = 0; dwe = 0; ia = '0; da = '0; dwd = '0;
        nxt = 0; iss_c = -1; rsp_c = -1; starve = 0;
        e_ird = '0; e_drd = '0; rsp_if = 0; rsp_we = 0; rsp_dat = '0;
        iss_addr = '0; iss_wd = '0; iss_we = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!iv) begin
                if ($urandom_range(0, 2) == 0) begin iv = 1; ia = raddr(); end
            end else if ($urandom_range(0, 15) == 0) iv = 0;
            if (!dv) begin
                if ($urandom_range(0, 2) == 0) begin
                    dv = 1; da = raddr(); dwe = $urandom_range(0, 1) == 1;
                    dwd = {$urandom, $urandom};
                end
            end else if ($urandom_range(0, 15) == 0) dv = 0;
            b1.if_valid = iv; b1.if_addr = ia;
            b1.d_valid = dv; b1.d_we = dwe; b1.d_addr = da; b1.d_wdata = dwd;
            #1;
            arb = (c >= nxt);
            gi = arb && iv && (!dv || starve >= LIM);
            gd = arb && dv && !gi;
            e_ir = (c == rsp_c) && rsp_if;
            e_dr = (c == rsp_c) && !rsp_if;
            if (e_ir) e_ird = rsp_dat[31:0];
            if (e_dr && !rsp_we) e_drd = rsp_dat;
            e_req = (c == iss_c);
            checks++;
            if ({b1.if_ready, b1.d_ready} !== {gi, gd}) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got %b%b exp %b%b", c,
                         b1.if_ready, b1.d_ready, gi, gd);
            end
            checks++;
            if ({b1.if_resp_valid, b1.d_resp_valid, b1.mem_req}
                !== {e_ir, e_dr, e_req}) begin
                errors++;
                $display("FAIL rnd_strobe c=%0d got %b%b%b exp %b%b%b", c,
                         b1.if_resp_valid, b1.d_resp_valid, b1.mem_req,
                         e_ir, e_dr, e_req);
            end
            checks++;
            if (b1.if_rdata !== e_ird || b1.d_rdata !== e_drd) begin
                errors++;
                $display("FAIL rnd_rdata c=%0d got %h %h exp %h %h", c,
                         b1.if_rdata, b1.d_rdata, e_ird, e_drd);
            end
            if (e_req) begin
                checks++;
                if (b1.mem_addr !== iss_addr || b1.mem_we !== iss_we ||
                    (iss_we && b1.mem_wdata !== iss_wd)) begin
                    errors++;
                    $display("FAIL rnd_issue c=%0d got %h %b %h exp %h %b %h",
                             c, b1.mem_addr, b1.mem_we, b1.mem_wdata,
                             iss_addr, iss_we, iss_wd);
                end
            end
            if (gi || gd) begin
                iss_c = c + 1;
                iss_addr = gi ? ia : da;
                iss_we = gd && dwe;
                iss_wd = dwd;
                rsp_c = c + 3;
                rsp_if = gi;
                rsp_we = iss_we;
                rsp_dat = rmem[iss_addr[9:3]];
                if (iss_we) rmem[iss_addr[9:3]] = dwd;
                nxt = c + 3;
            end else if (arb) begin
                nxt = c + 1;
            end
            if (!iv || gi) starve = 0;
            else if (arb && starve < 255) starve++;
            if (gi) iv = 0;
            if (gd) dv = 0;
        end
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

`ifdef MEM_ARB_PERF_EN
    // Fetch asks in cycles 0..12 and wins at 6, 9 and 12; data wins at
    // 0 and 3. That leaves 13 - 3 = 10 fetch stall cycles.
    task automatic test_perf();
        pulse_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            b1.if_valid = (c <= 12); b1.if_addr = 64'h2000;
            b1.d_valid = (c <= 3); b1.d_we = (c >= 1);
            b1.d_addr = 64'h180; b1.d_wdata = 64'h77;
            #1;
        end
        checks++;
        if (p1_ifg !== 32'd3 || p1_dg !== 32'd2 || p1_st !== 32'd10) begin
            errors++;
            $display("FAIL perf got ifg=%0d dg=%0d st=%0d exp 3 2 10",
                     p1_ifg, p1_dg, p1_st);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_fetch_only();
        test_store_load();
        test_starvation();
        test_latency3();
        test_reset_mid();
        test_random();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-port unified memory between two requesters: instruction fetch (read-only, 32-bit) and data load/store (64-bit read/write).
- Fixed-priority arbitration favours data, with a starvation guard for fetch.
- Blocking: at most one memory transaction outstanding.
- Sits between fetch/control logic and the memory model in tinker_core.

Parameters:
- ADDR_W, 64, address width.
- MEM_LAT, 1, cycles from mem_req to valid mem_rdata (legal 1..15).
- STARVE_LIMIT, 4, consecutive lost arbitration cycles before fetch is forced to win (legal 1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  fetch request accepted this cycle.
- if_resp_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_valid  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  64  store data.
- d_ready  out  1  data request accepted this cycle.
- d_resp_valid  out  1  one-cycle pulse; load data valid, or store acknowledged.
- d_rdata  out  64  load data.
- mem_req  out  1  one-cycle memory command strobe.
- mem_we  out  1  memory write enable, qualified by mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, valid MEM_LAT cycles after the mem_req cycle.

Behaviour:
- Reset values: state IDLE; all outputs 0; starvation counter 0; latency counter 0.
- FSM states:
  - IDLE: combinational ready to the winner. Handshake = valid & ready. On handshake, latch addr/we/wdata/owner; next state ISSUE.
  - ISSUE: mem_req=1 for exactly one cycle; mem_we/mem_addr/mem_wdata driven from the latch; load counter with MEM_LAT; next state WAIT.
  - WAIT: decrement the counter. When it reaches 0, register mem_rdata into the owner's rdata; next state RESP.
  - RESP: owner's resp_valid=1 for one cycle; ready logic is active as in IDLE (back-to-back accept allowed); next state IDLE, or ISSUE if a handshake occurred.
- Latency, MEM_LAT=1: handshake at cycle 0, mem_req at 1, mem_rdata sampled at 2, resp_valid at 3. Throughput is one transaction per MEM_LAT+2 cycles.
- Arbitration when both are valid: data wins, unless the starvation counter is ≥ STARVE_LIMIT, in which case fetch wins.
- Only one of if_ready/d_ready is ever high. Neither is high in ISSUE or WAIT.
- Starvation counter:
  - increments (saturating at 255) in each arbitrating cycle where if_valid=1 and fetch is not granted;
  - clears on a fetch grant or when if_valid=0.
- if_rdata = mem_rdata[31:0] as registered.
- Stores:
  - d_rdata is held unchanged.
  - d_resp_valid pulses as the acknowledge, with the same timing as a load.
- rdata outputs hold their last value between responses.
- Requester rule: valid and payload stay stable until ready. A valid that drops before ready is legal and simply not served.
- Reset mid-transaction: immediate return to IDLE and all strobes 0. The pending response is dropped. A store already issued to memory is not undone.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds three output ports: perf_if_grants[31:0], perf_d_grants[31:0], perf_if_stall[31:0].
  - perf_if_stall counts cycles with if_valid=1 and no fetch handshake.
  - All three saturate at 2^32-1 and clear on reset.
- When undefined, these ports and their counters do not exist. Core behaviour is identical in both builds.

Decomposition:
- Shared package tinker_mem_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - owner enum {OWN_IF, OWN_D};
  - constants RESET_PC (64'h2000) and MEM_SIZE (524288) for use by neighbouring blocks.
- One natural sub-module, mem_arb_perf, holds the saturating counters. It is instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Fetch only, MEM_LAT=1:
  - if_valid, addr 0x2000, memory word 0x1234ABCD → if_ready at cycle 0, mem_req/mem_addr=0x2000 at 1, if_resp_valid with if_rdata=0x1234ABCD at 3.
- Store then load to 0x100, wdata 0xDEADBEEF_00000001:
  - mem_we=1 on the store's ISSUE cycle; d_resp_valid ack after the store;
  - the load returns d_rdata=0xDEADBEEF_00000001.
- if_valid and d_valid both held high continuously, STARVE_LIMIT=4:
  - data is granted while the starvation counter is below 4;
  - fetch is granted at the first arbitration once the counter reaches 4, and the counter clears;
  - if_ready and d_ready are never high together.
- MEM_LAT=3: resp_valid arrives 5 cycles after the handshake; a new request presented in the RESP cycle is accepted in that cycle.
- Reset asserted during WAIT: all outputs 0 immediately, no resp_valid afterwards; a fresh fetch after reset completes normally.
- With MEM_ARB_PERF_EN: 3 fetches and 2 data ops → perf_if_grants=3, perf_d_grants=2, and perf_if_stall equals the counted contention cycles.
